// File: rtl/chart_note_sequencer.sv
// Chart playback stage: loads a chart from storage, steps its notes
// at a fixed slot rate and scores the player's keys per slot.
`ifndef CHART_LEN
`define CHART_LEN 8
`endif

package chart_pkg;
  localparam int CHART_LEN = `CHART_LEN;

  typedef logic [8:0] note_t;

  typedef struct packed {
    logic [15:0] note_cnt;
  } chart_info_t;

  typedef struct packed {
    chart_info_t           info;
    note_t [CHART_LEN-1:0] notes;
  } Chart;
endpackage

module chart_note_sequencer
  import chart_pkg::*;
#(
  parameter int TICKS_PER_SLOT = 25_000_000,
  parameter int LOAD_WAIT      = 3
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [7:0]  chart_id_sel,
  input  logic        pause,
  input  logic        abort,
  output logic [7:0]  read_chart_id,
  input  Chart        chart_data,
  input  logic [8:0]  player_keys,
  output logic [8:0]  cur_note,
  output logic [8:0]  next_note,
  output logic [15:0] slot_idx,
  output logic [15:0] hit_cnt,
  output logic [15:0] note_total,
  output logic        playing,
  output logic        done
);

  localparam int TW = $clog2(TICKS_PER_SLOT);
  localparam int WW = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT) : 1;

  localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_SLOT - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(LOAD_WAIT - 1);
  localparam logic [15:0]   LEN16     = 16'(CHART_LEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [TW-1:0] tick;
  logic [WW-1:0] wait_cnt;
  logic [15:0]   n_len;
  logic [15:0]   n_clip;
  logic [15:0]   nxt_idx;
  logic          active;

  // Mux by compare so an index past the chart never addresses storage.
  function automatic note_t note_at(input Chart c,
                                    input logic [15:0] idx);
    note_at = '0;
    for (int i = 0; i < CHART_LEN; i++) begin
      if (idx == 16'(i)) note_at = c.notes[i];
    end
  endfunction

  assign n_clip  = (chart_data.info.note_cnt > LEN16) ?
                   LEN16 : chart_data.info.note_cnt;
  assign nxt_idx = slot_idx + 16'd1;
  assign active  = (state == S_PLAY) || (state == S_PAUSE);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= S_IDLE;
      tick          <= '0;
      wait_cnt      <= '0;
      n_len         <= '0;
      read_chart_id <= '0;
      cur_note      <= '0;
      next_note     <= '0;
      slot_idx      <= '0;
      hit_cnt       <= '0;
      note_total    <= '0;
      playing       <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      // Notes trail slot_idx by one cycle, including the final slot.
      cur_note  <= active ? note_at(chart_data, slot_idx) : '0;
      next_note <= (active && nxt_idx < n_len) ?
                   note_at(chart_data, nxt_idx) : '0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start && chart_id_sel != 8'd0) begin
            state         <= S_LOAD;
            read_chart_id <= chart_id_sel;
            slot_idx      <= '0;
            hit_cnt       <= '0;
            note_total    <= '0;
            tick          <= '0;
            wait_cnt      <= '0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state         <= S_IDLE;
            read_chart_id <= '0;
          end else if (wait_cnt == LAST_WAIT) begin
            n_len <= n_clip;
            if (n_clip == 16'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_PLAY;
              playing <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_PLAY, S_PAUSE: begin
          if (abort) begin
            state         <= S_IDLE;
            read_chart_id <= '0;
            cur_note      <= '0;
            next_note     <= '0;
            playing       <= 1'b0;
          end else if (pause) begin
            state <= S_PAUSE;
          end else if (tick != LAST_TICK) begin
            state <= S_PLAY;
            tick  <= tick + 1'b1;
          end else begin
            state <= S_PLAY;
            if (cur_note != '0) begin
              if (note_total != 16'hFFFF)
                note_total <= note_total + 16'd1;
              if (player_keys == cur_note && hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (slot_idx == n_len - 16'd1) begin
              state   <= S_DONE;
              done    <= 1'b1;
              playing <= 1'b0;
            end else begin
              slot_idx <= nxt_idx;
              tick     <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chart_note_sequencer.sv
// Scoreboard bench: stimulus queues expected play runs, note segments
// and done pulses; a negedge monitor pops and compares them.
module tb_chart_note_sequencer;
  import chart_pkg::*;

  localparam int    TPS = 4;
  localparam int    LW  = 3;
  localparam note_t C4  = 9'h081;
  localparam note_t G4  = 9'h090;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  chart_id_sel = '0;
  logic        pause = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  read_chart_id;
  Chart        chart_data;
  logic [8:0]  player_keys = '0;
  logic [8:0]  cur_note;
  logic [8:0]  next_note;
  logic [15:0] slot_idx;
  logic [15:0] hit_cnt;
  logic [15:0] note_total;
  logic        playing;
  logic        done;

  always #5 clk = ~clk;

  chart_note_sequencer #(
    .TICKS_PER_SLOT(TPS),
    .LOAD_WAIT(LW)
  ) dut (
    .clk(clk),
    .sys_rst_n(sys_rst_n),
    .start(start),
    .chart_id_sel(chart_id_sel),
    .pause(pause),
    .abort(abort),
    .read_chart_id(read_chart_id),
    .chart_data(chart_data),
    .player_keys(player_keys),
    .cur_note(cur_note),
    .next_note(next_note),
    .slot_idx(slot_idx),
    .hit_cnt(hit_cnt),
    .note_total(note_total),
    .playing(playing),
    .done(done)
  );

  Chart ch1, ch2, ch3;

  always_comb begin
    case (read_chart_id)
      8'd1:    chart_data = ch1;
      8'd2:    chart_data = ch2;
      8'd3:    chart_data = ch3;
      default: chart_data = '0;
    endcase
  end

  function automatic note_t nt(input int i);
    return {2'd2, 7'(1 << (i % 7))};
  endfunction

  typedef struct {
    int         lat;
    int         len;
    logic [7:0] rd_first;
    logic [7:0] rd_end;
  } play_t;

  typedef struct {
    note_t cur;
    note_t nxt;
    int    len;
  } seg_t;

  typedef struct {
    int          lat;
    logic [15:0] slot;
    logic [15:0] hit;
    logic [15:0] tot;
    logic [7:0]  rd;
  } done_t;

  play_t q_play[$];
  seg_t  q_seg[$];
  done_t q_done[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic unexpected(input string what, input int val);
    n_cmp++;
    n_bad++;
    $display("FAIL unexpected %s: got %0d, want none", what, val);
  endtask

  task automatic exp_run(input int lat, input int len,
                         input logic [7:0] rf, input logic [7:0] re);
    play_t p;
    p.lat = lat; p.len = len; p.rd_first = rf; p.rd_end = re;
    q_play.push_back(p);
  endtask

  task automatic exp_seg(input note_t c, input note_t n, input int len);
    seg_t s;
    s.cur = c; s.nxt = n; s.len = len;
    q_seg.push_back(s);
  endtask

  task automatic exp_fin(input int lat, input int slot, input int hit,
                         input int tot, input logic [7:0] rd);
    done_t d;
    d.lat = lat; d.slot = 16'(slot); d.hit = 16'(hit);
    d.tot = 16'(tot); d.rd = rd;
    q_done.push_back(d);
  endtask

  // Monitor
  int          since_start = 0;
  int          run_lat = 0;
  int          run_len = 0;
  logic [7:0]  run_rd = '0;
  logic        run_on = 1'b0;
  logic [17:0] seg_val = '0;
  int          seg_len = 0;

  always @(negedge clk) begin
    play_t p;
    seg_t  s;
    done_t d;
    since_start = start ? 0 : since_start + 1;
    if (since_start == 1) run_rd = read_chart_id;
    if (playing && !run_on) begin
      run_lat = since_start;
      run_len = 0;
    end
    if (playing) run_len++;
    if (!playing && run_on) begin
      if (q_play.size() == 0) unexpected("play run", run_len);
      else begin
        p = q_play.pop_front();
        chk("run latency", run_lat, p.lat);
        chk("run length", run_len, p.len);
        chk("run read id", 32'(run_rd), 32'(p.rd_first));
        chk("end read id", 32'(read_chart_id), 32'(p.rd_end));
      end
    end
    run_on = playing;
    if ({cur_note, next_note} != seg_val) begin
      if (seg_val != '0) begin
        if (q_seg.size() == 0) unexpected("note segment", seg_len);
        else begin
          s = q_seg.pop_front();
          chk("seg cur_note", 32'(seg_val[17:9]), 32'(s.cur));
          chk("seg next_note", 32'(seg_val[8:0]), 32'(s.nxt));
          chk("seg length", seg_len, s.len);
        end
      end
      seg_val = {cur_note, next_note};
      seg_len = 1;
    end else begin
      seg_len++;
    end
    if (done) begin
      if (q_done.size() == 0) unexpected("done pulse", since_start);
      else begin
        d = q_done.pop_front();
        chk("done latency", since_start, d.lat);
        chk("done slot_idx", 32'(slot_idx), 32'(d.slot));
        chk("done hit_cnt", 32'(hit_cnt), 32'(d.hit));
        chk("done note_total", 32'(note_total), 32'(d.tot));
        chk("done read id", 32'(read_chart_id), 32'(d.rd));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input logic [7:0] id);
    step(1);
    start = 1'b1;
    chart_id_sel = id;
    step(1);
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " read_chart_id"}, 32'(read_chart_id), 0);
    chk({tag, " cur_note"}, 32'(cur_note), 0);
    chk({tag, " next_note"}, 32'(next_note), 0);
    chk({tag, " slot_idx"}, 32'(slot_idx), 0);
    chk({tag, " hit_cnt"}, 32'(hit_cnt), 0);
    chk({tag, " note_total"}, 32'(note_total), 0);
    chk({tag, " playing"}, 32'(playing), 0);
    chk({tag, " done"}, 32'(done), 0);
  endtask

  initial begin
    ch1 = '0;
    ch1.info.note_cnt = 16'd3;
    ch1.notes[0] = C4;
    ch1.notes[2] = G4;
    ch2 = '0;
    ch3 = '0;
    ch3.info.note_cnt = 16'hFFFF;
    for (int i = 0; i < CHART_LEN; i++) ch3.notes[i] = nt(i);

    #2 sys_rst_n = 1'b0;
    step(2);
    chk_all_zero("reset");
    sys_rst_n = 1'b1;
    step(2);

    // start with id 0 must be ignored
    launch(8'd0);
    step(6);
    chk("id0 read_chart_id", 32'(read_chart_id), 0);
    chk("id0 playing", 32'(playing), 0);

    // plain play, hit on slot 0 only
    player_keys = C4;
    exp_run(4, 12, 8'd1, 8'd1);
    exp_seg(C4, '0, 4);
    exp_seg('0, G4, 4);
    exp_seg(G4, '0, 4);
    exp_fin(16, 2, 1, 2, 8'd1);
    launch(8'd1);
    step(8);
    player_keys = '0;
    step(12);
    chk("done cur_note", 32'(cur_note), 0);
    chk("done playing", 32'(playing), 0);

    // pause 10 cycles in slot 1, miss slot 0, hit slot 2
    player_keys = G4;
    exp_run(4, 22, 8'd1, 8'd1);
    exp_seg(C4, '0, 4);
    exp_seg('0, G4, 14);
    exp_seg(G4, '0, 4);
    exp_fin(26, 2, 1, 2, 8'd1);
    launch(8'd1);
    step(8);
    pause = 1'b1;
    step(5);
    chk("paused slot_idx", 32'(slot_idx), 1);
    chk("paused hit_cnt", 32'(hit_cnt), 0);
    chk("paused playing", 32'(playing), 1);
    step(5);
    pause = 1'b0;
    step(12);

    // abort in slot 1, then full replay
    player_keys = C4;
    exp_run(4, 6, 8'd1, 8'd0);
    exp_seg(C4, '0, 4);
    exp_seg('0, G4, 1);
    launch(8'd1);
    step(8);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort read_chart_id", 32'(read_chart_id), 0);
    chk("abort playing", 32'(playing), 0);
    chk("abort cur_note", 32'(cur_note), 0);
    exp_run(4, 12, 8'd1, 8'd1);
    exp_seg(C4, '0, 4);
    exp_seg('0, G4, 4);
    exp_seg(G4, '0, 4);
    exp_fin(16, 2, 1, 2, 8'd1);
    launch(8'd1);
    step(20);

    // empty chart
    exp_fin(4, 0, 0, 0, 8'd2);
    launch(8'd2);
    step(8);
    chk("empty playing", 32'(playing), 0);

    // oversized note_cnt clips to CHART_LEN
    player_keys = '0;
    exp_run(4, TPS * CHART_LEN, 8'd3, 8'd3);
    for (int i = 0; i < CHART_LEN; i++)
      exp_seg(nt(i), (i < CHART_LEN - 1) ? nt(i + 1) : '0, 4);
    exp_fin(TPS * CHART_LEN + 4, CHART_LEN - 1, 0, CHART_LEN, 8'd3);
    launch(8'd3);
    step(TPS * CHART_LEN + 8);

    // async reset mid-play
    player_keys = C4;
    exp_run(4, 6, 8'd1, 8'd0);
    exp_seg(C4, '0, 4);
    exp_seg('0, G4, 1);
    launch(8'd1);
    step(9);
    sys_rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    step(2);
    sys_rst_n = 1'b1;
    step(4);

    chk("play queue left", q_play.size(), 0);
    chk("segment queue left", q_seg.size(), 0);
    chk("done queue left", q_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
